// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the program counter, keeps one request outstanding
// to instruction memory and hands each returned word plus its PC to decode.
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [ADDR_WIDTH-1:0] fetch_address,
  output logic                  fetch_valid,
  input  logic                  fetch_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   fetch_address_q;
  logic                    fetch_valid_q;
  logic [DATA_WIDTH-1:0]   instr_out_q;
  logic [ADDR_WIDTH-1:0]   instr_pc_q;
  logic                    instr_valid_q;
  logic                    halted_q;
  logic                    redir_pend_q;
  logic [ADDR_WIDTH-1:0]   redir_addr_q;
  logic                    halt_pend_q;

  logic                    halt_now_d;
  logic                    redir_hit_d;
  logic [ADDR_WIDTH-1:0]   redir_tgt_d;
  logic [ADDR_WIDTH-1:0]   next_pc_d;
  state_e                  go_state_d;

  // A fresh redirect this cycle overrides an older pending target.
  always_comb begin
    halt_now_d  = halt_req | halt_pend_q;
    redir_hit_d = redirect_valid | redir_pend_q;
    if (redirect_valid) begin
      redir_tgt_d = redirect_addr;
    end else begin
      redir_tgt_d = redir_addr_q;
    end
    next_pc_d = fetch_address_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    if (halt_now_d) begin
      go_state_d = S_HALT;
    end else begin
      go_state_d = S_FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      fetch_address_q <= RESET_ADDR;
      fetch_valid_q   <= 1'b0;
      instr_out_q     <= {DATA_WIDTH{1'b0}};
      instr_pc_q      <= {ADDR_WIDTH{1'b0}};
      instr_valid_q   <= 1'b0;
      halted_q        <= 1'b0;
      redir_pend_q    <= 1'b0;
      redir_addr_q    <= {ADDR_WIDTH{1'b0}};
      halt_pend_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q       <= go_state_d;
            fetch_valid_q <= ~halt_now_d;
            halted_q      <= halt_now_d;
            halt_pend_q   <= 1'b0;
          end else begin
            halt_pend_q <= halt_now_d;
          end
        end
        S_FETCH: begin
          halt_pend_q <= halt_now_d;
          if (fetch_ready) begin
            fetch_valid_q <= 1'b0;
            state_q       <= S_WAIT;
            if (redirect_valid) begin
              redir_pend_q <= 1'b1;
              redir_addr_q <= redirect_addr;
            end
          end else if (redirect_valid) begin
            fetch_address_q <= redirect_addr;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (redir_hit_d) begin
              // Returned word belongs to the abandoned path: drop it.
              fetch_address_q <= redir_tgt_d;
              redir_pend_q    <= 1'b0;
              state_q         <= go_state_d;
              fetch_valid_q   <= ~halt_now_d;
              halted_q        <= halt_now_d;
              halt_pend_q     <= 1'b0;
            end else begin
              instr_out_q   <= mem_rdata;
              instr_pc_q    <= fetch_address_q;
              instr_valid_q <= 1'b1;
              state_q       <= S_HOLD;
              halt_pend_q   <= halt_now_d;
            end
          end else begin
            halt_pend_q <= halt_now_d;
            if (redirect_valid) begin
              redir_pend_q <= 1'b1;
              redir_addr_q <= redirect_addr;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid || instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= go_state_d;
            fetch_valid_q <= ~halt_now_d;
            halted_q      <= halt_now_d;
            halt_pend_q   <= 1'b0;
            if (redirect_valid) begin
              fetch_address_q <= redirect_addr;
            end else begin
              fetch_address_q <= next_pc_d;
            end
          end else begin
            halt_pend_q <= halt_now_d;
          end
        end
        S_HALT: begin
          if (start && !halt_req) begin
            state_q       <= S_FETCH;
            fetch_valid_q <= 1'b1;
            halted_q      <= 1'b0;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          fetch_valid_q <= 1'b0;
          instr_valid_q <= 1'b0;
          halted_q      <= 1'b0;
          redir_pend_q  <= 1'b0;
          halt_pend_q   <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_address = fetch_address_q;
  assign fetch_valid   = fetch_valid_q;
  assign instr_out     = instr_out_q;
  assign instr_pc      = instr_pc_q;
  assign instr_valid   = instr_valid_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a transaction-level model predicts handshakes and
// delivered instructions; a second instance with RESET_ADDR=FFFE exercises address wrap.
module tb_fetch_sequencer;

  localparam int P_IDLE = 0, P_FETCH = 1, P_WAIT = 2, P_HOLD = 3, P_HALT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, halt_req, redirect_valid;
  logic [15:0] redirect_addr;
  logic [15:0] fetch_address;
  logic        fetch_valid, fetch_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid, instr_ready, halted;

  logic [15:0] w_fetch_address;
  logic        w_fetch_valid, w_rvalid, w_instr_valid, w_halted;
  logic [31:0] w_rdata, w_instr_out;
  logic [15:0] w_instr_pc;
  logic        w_one;
  logic        w_zero;
  logic [15:0] w_zaddr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .RESET_ADDR(16'h0000)) u_dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .fetch_address(fetch_address), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .halted(halted)
  );

  assign w_one   = 1'b1;
  assign w_zero  = 1'b0;
  assign w_zaddr = 16'h0000;

  fetch_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .RESET_ADDR(16'hFFFE)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .halt_req(w_zero),
    .redirect_valid(w_zero), .redirect_addr(w_zaddr),
    .fetch_address(w_fetch_address), .fetch_valid(w_fetch_valid), .fetch_ready(w_one),
    .mem_rvalid(w_rvalid), .mem_rdata(w_rdata), .instr_out(w_instr_out),
    .instr_pc(w_instr_pc), .instr_valid(w_instr_valid), .instr_ready(w_one),
    .halted(w_halted)
  );

  // Ideal memory for the wrap instance: data one cycle after each accept.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      w_rvalid <= 1'b0;
      w_rdata  <= 32'h0;
    end else begin
      w_rvalid <= w_fetch_valid;
      w_rdata  <= {16'h0000, w_fetch_address} + 32'h0000_A000;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_phase;
  logic [15:0] m_addr, m_pc;
  logic        m_drop, m_halt, hn;
  logic [47:0] sb[$];
  logic [47:0] ent;

  task automatic m_go(input logic h);
    m_phase = h ? P_HALT : P_FETCH;
    m_halt  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      m_phase = P_IDLE; m_addr = 16'h0000; m_pc = 16'h0000;
      m_drop = 1'b0; m_halt = 1'b0; sb.delete();
    end else begin
      hn = halt_req || m_halt;
      chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_phase == P_FETCH});
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_phase == P_HOLD});
      chk("halted", {31'b0, halted}, {31'b0, m_phase == P_HALT});
      if (m_phase == P_FETCH) chk("fetch_address", {16'h0, fetch_address}, {16'h0, m_addr});
      if (m_phase == P_HOLD && sb.size() > 0) begin
        ent = sb[0];
        chk("instr_pc", {16'h0, instr_pc}, {16'h0, ent[47:32]});
        chk("instr_out", instr_out, ent[31:0]);
      end
      case (m_phase)
        P_IDLE, P_HALT: begin
          if (start) m_go(hn);
          else if (m_phase == P_IDLE) m_halt = hn;
        end
        P_FETCH: begin
          m_halt = hn;
          if (fetch_ready) begin
            m_pc = m_addr; m_drop = 1'b0; m_phase = P_WAIT;
            if (redirect_valid) begin m_drop = 1'b1; m_addr = redirect_addr; end
          end else if (redirect_valid) begin
            m_addr = redirect_addr;
          end
        end
        P_WAIT: begin
          if (redirect_valid) begin m_drop = 1'b1; m_addr = redirect_addr; end
          if (mem_rvalid && m_drop) begin
            m_go(hn);
          end else if (mem_rvalid) begin
            sb.push_back({m_pc, {16'h0000, m_pc} + 32'h0000_A000});
            m_addr = m_pc + 16'd1; m_phase = P_HOLD; m_halt = hn;
          end else begin
            m_halt = hn;
          end
        end
        P_HOLD: begin
          if (redirect_valid) begin
            void'(sb.pop_front()); m_addr = redirect_addr; m_go(hn);
          end else if (instr_ready) begin
            void'(sb.pop_front()); m_go(hn);
          end else begin
            m_halt = hn;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // Wrap instance: address sequence FFFE, FFFF, 0000, ... and 3-cycle spacing.
  logic [15:0] w_exp;
  logic [15:0] w_q[$];
  logic [15:0] w_p;
  int w_cyc, w_last;
  always @(negedge clk) begin
    if (reset) begin
      w_exp = 16'hFFFE; w_q.delete(); w_cyc = 0; w_last = -1;
    end else begin
      w_cyc++;
      if (w_fetch_valid) begin
        chk("wrap_fetch_address", {16'h0, w_fetch_address}, {16'h0, w_exp});
        w_q.push_back(w_exp);
        w_exp = w_exp + 16'd1;
      end
      if (w_instr_valid) begin
        chk("wrap_pending", {31'b0, w_q.size() > 0}, 32'd1);
        if (w_q.size() > 0) begin
          w_p = w_q.pop_front();
          chk("wrap_instr_pc", {16'h0, w_instr_pc}, {16'h0, w_p});
          chk("wrap_instr_out", w_instr_out, {16'h0, w_p} + 32'h0000_A000);
        end
        if (w_last >= 0) chk("wrap_spacing", w_cyc - w_last, 32'd3);
        w_last = w_cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  int p_ready = 100, p_iready = 100, p_redir = 0, p_start = 0, p_halt = 0, mem_dly = 0;
  logic        acc_s = 1'b0;
  logic [15:0] acc_addr = 16'h0;
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [15:0] mem_a = 16'h0;
  logic        redir_once = 1'b0, start_once = 1'b0, halt_once = 1'b0, rv_once = 1'b0;
  logic [15:0] redir_once_addr = 16'h0;

  task automatic step();
    @(posedge clk); #1;
    if (acc_s) begin mem_busy = 1'b1; mem_cnt = $urandom_range(0, mem_dly); mem_a = acc_addr; end
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (rv_once) begin
      mem_rvalid = 1'b1; rv_once = 1'b0;
    end else if (mem_busy && mem_cnt == 0) begin
      mem_rvalid = 1'b1; mem_rdata = {16'h0000, mem_a} + 32'h0000_A000; mem_busy = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
    end
    fetch_ready = ($urandom_range(0, 99) < p_ready);
    instr_ready = ($urandom_range(0, 99) < p_iready);
    redirect_valid = 1'b0;
    redirect_addr  = $urandom;
    if (redir_once) begin
      redirect_valid = 1'b1; redirect_addr = redir_once_addr; redir_once = 1'b0;
    end else if ($urandom_range(0, 99) < p_redir) begin
      redirect_valid = 1'b1;
    end
    start    = start_once || ($urandom_range(0, 99) < p_start);
    halt_req = halt_once  || ($urandom_range(0, 99) < p_halt);
    start_once = 1'b0; halt_once = 1'b0;
    @(negedge clk);
    acc_s = fetch_valid && fetch_ready;
    acc_addr = fetch_address;
  endtask

  task automatic wait_acc(input logic [15:0] a, input int lim);
    logic found = 1'b0;
    for (int i = 0; i < lim && !found; i++) begin
      step();
      if (acc_s && acc_addr == a) found = 1'b1;
    end
    chk($sformatf("accept_%h", a), {31'b0, found}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_addr = 16'h0; fetch_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fetch_address", {16'h0, fetch_address}, 32'h0);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_wrap_address", {16'h0, w_fetch_address}, 32'h0000_FFFE);
    reset = 1'b0;

    // ideal flow from reset, then 4-cycle fetch_ready stall on address 3
    start_once = 1'b1;
    wait_acc(16'h0002, 20);
    p_ready = 0;
    for (int i = 0; i < 20 && !(fetch_valid && fetch_address == 16'h0003); i++) step();
    chk("stall_at_3", {31'b0, fetch_valid && fetch_address == 16'h0003}, 32'd1);
    repeat (3) step();
    p_ready = 100;
    step();
    chk("accept_after_stall", {15'b0, acc_s, acc_addr}, {16'h0001, 16'h0003});

    // decode back-pressure for 5 cycles while holding instruction 3
    p_iready = 0;
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    repeat (4) step();
    chk("hold_pc", {16'h0, instr_pc}, 32'h3);
    chk("hold_no_fetch", {31'b0, fetch_valid}, 32'd0);
    p_iready = 100;

    // redirect during WAIT of address 5
    wait_acc(16'h0005, 20);
    redir_once = 1'b1; redir_once_addr = 16'h0040;
    wait_acc(16'h0040, 10);
    wait_acc(16'h0041, 10);

    // halt during WAIT of address 7, then resume at 8
    redir_once = 1'b1; redir_once_addr = 16'h0007;
    wait_acc(16'h0007, 20);
    halt_once = 1'b1;
    repeat (6) step();
    chk("halted_hold", {31'b0, halted}, 32'd1);
    chk("halted_no_fetch", {31'b0, fetch_valid}, 32'd0);
    start_once = 1'b1;
    wait_acc(16'h0008, 10);

    // randomized traffic
    p_ready = 70; p_iready = 70; mem_dly = 2; p_redir = 8; p_start = 10; p_halt = 3;
    repeat (3000) step();

    // async reset in the middle of WAIT, then stray rvalid while IDLE
    p_ready = 100; p_iready = 100; mem_dly = 0; p_redir = 0; p_halt = 0; p_start = 20;
    for (int i = 0; i < 40 && !acc_s; i++) step();
    chk("pre_reset_accept", {31'b0, acc_s}, 32'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_fetch_address", {16'h0, fetch_address}, 32'h0);
    chk("mid_rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("mid_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_rst_instr_out", instr_out, 32'h0);
    chk("mid_rst_instr_pc", {16'h0, instr_pc}, 32'h0);
    chk("mid_rst_halted", {31'b0, halted}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; mem_busy = 1'b0; acc_s = 1'b0; p_start = 0; rv_once = 1'b1;
    repeat (3) step();
    chk("idle_ignores_rvalid", {31'b0, instr_valid}, 32'd0);
    start_once = 1'b1;
    wait_acc(16'h0000, 10);
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
